comparador_serial: RTL and testbench

Parametrised, bit-serial magnitude comparator for two WIDTH-bit operands. It extends the team's 2-bit combinational equality comparator with three additions: greater-than and less-than results, a signed/unsigned mode, and a start/done handshake. The block captures both operands on `start` and scans them MSB-first, one bit per clock. It then reports a registered, mutually exclusive `eq`/`gt`/`lt` result. It sits beside the datapath wherever a compare result may arrive late, trading latency for a single-bit compare cell.

---
 rtl/comparador_serial.sv | 130 +++++++++++++
 tb/tb_comparador_serial.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/comparador_serial.sv
// Bit-serial MSB-first magnitude comparator with signed/unsigned mode and a start/done handshake.
// Reports a registered, mutually exclusive eq/gt/lt result once the scan finishes.
module comparador_serial #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             dir_q, dir_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

    logic             bit_a, bit_b, diff, msb_flip, dec_nxt, dir_nxt, finish;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        dir_d     = dir_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;

        bit_a    = a_q[idx_q];
        bit_b    = b_q[idx_q];
        diff     = !decided_q && (bit_a != bit_b);
        // In two's complement the sign bit carries negative weight, so a 1 there means smaller.
        msb_flip = sgn_q && (idx_q == MSB_IDX);
        dec_nxt  = decided_q | diff;
        dir_nxt  = diff ? (msb_flip ? bit_b : bit_a) : dir_q;
        finish   = (EARLY_EXIT && diff) || (idx_q == '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = A;
                    b_d       = B;
                    sgn_d     = signed_mode;
                    idx_d     = MSB_IDX;
                    decided_d = 1'b0;
                    dir_d     = 1'b0;
                    eq_d      = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                    state_d   = S_COMPARE;
                end
            end
            S_COMPARE: begin
                decided_d = dec_nxt;
                dir_d     = dir_nxt;
                // Outputs stay clear while scanning; the verdict is published only on entry to DONE.
                if (finish) begin
                    eq_d    = !dec_nxt;
                    gt_d    = dec_nxt && dir_nxt;
                    lt_d    = dec_nxt && !dir_nxt;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            decided_q <= 1'b0;
            dir_q     <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            dir_q     <= dir_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
        end
    end

    // Operand registers are pure data and only matter once loaded by an accepted start.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sgn_q <= sgn_d;
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Directed bench for comparador_serial: one early-exit and one full-scan instance share all inputs.
module tb_comparador_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sgn;
    logic [7:0] a, b;
    logic       busy_e, done_e, eq_e, gt_e, lt_e;
    logic       busy_f, done_f, eq_f, gt_f, lt_f;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    comparador_serial #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sgn), .A(a), .B(b),
        .busy(busy_e), .done(done_e), .eq(eq_e), .gt(gt_e), .lt(lt_e)
    );

    comparador_serial #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sgn), .A(a), .B(b),
        .busy(busy_f), .done(done_f), .eq(eq_f), .gt(gt_f), .lt(lt_f)
    );

    // res is {eq, gt, lt}; lat_e is the early-exit done cycle; full scan is always 9
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sgn;
        logic [2:0] res;
        int         lat_e;
    } vec_t;

    localparam int LAT_F = 9;
    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vs);
        @(negedge clk);
        a     = va;
        b     = vb;
        sgn   = vs;
        start = 1'b1;
    endtask

    // Called right after launch; cycle n is the n-th cycle after the accepting edge.
    task automatic observe(input vec_t v, input int ncyc, input bit disturb);
        int first_e = -1;
        int first_f = -1;
        int cnt_e   = 0;
        int cnt_f   = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("busy_e_after_start", busy_e, 1'b1);
                check("busy_f_after_start", busy_f, 1'b1);
                check("res_e_during_compare", {eq_e, gt_e, lt_e}, 3'b000);
                check("res_f_during_compare", {eq_f, gt_f, lt_f}, 3'b000);
            end
            if (done_e) begin
                cnt_e++;
                if (first_e < 0) begin
                    first_e = n;
                    check("res_e_at_done", {eq_e, gt_e, lt_e}, v.res);
                end
            end
            if (done_f) begin
                cnt_f++;
                if (first_f < 0) begin
                    first_f = n;
                    check("res_f_at_done", {eq_f, gt_f, lt_f}, v.res);
                end
            end
            if (first_e > 0 && n == first_e + 1) check("busy_e_after_done", {busy_e, done_e}, 2'b00);
            if (first_f > 0 && n == first_f + 1) check("busy_f_after_done", {busy_f, done_f}, 2'b00);
            if (disturb) begin
                start = (n <= 4);
                a     = 8'hFF;
            end else begin
                start = 1'b0;
            end
        end
        check("lat_e", first_e, v.lat_e);
        check("lat_f", first_f, LAT_F);
        check("done_e_pulses", cnt_e, 1);
        check("done_f_pulses", cnt_f, 1);
        if (ncyc > LAT_F) begin
            check("res_e_held", {eq_e, gt_e, lt_e}, v.res);
            check("res_f_held", {eq_f, gt_f, lt_f}, v.res);
        end
    endtask

    initial begin
        vec_t v;

        vecs[0]  = '{a: 8'h5A, b: 8'h5A, sgn: 1'b0, res: R_EQ, lat_e: 9};
        vecs[1]  = '{a: 8'h80, b: 8'h7F, sgn: 1'b0, res: R_GT, lat_e: 2};
        vecs[2]  = '{a: 8'h80, b: 8'h7F, sgn: 1'b1, res: R_LT, lat_e: 2};
        vecs[3]  = '{a: 8'h01, b: 8'h02, sgn: 1'b0, res: R_LT, lat_e: 8};
        vecs[4]  = '{a: 8'hFE, b: 8'hFF, sgn: 1'b1, res: R_LT, lat_e: 9};
        vecs[5]  = '{a: 8'h7F, b: 8'h80, sgn: 1'b1, res: R_GT, lat_e: 2};
        vecs[6]  = '{a: 8'h00, b: 8'hFF, sgn: 1'b0, res: R_LT, lat_e: 2};
        vecs[7]  = '{a: 8'hC3, b: 8'hC1, sgn: 1'b0, res: R_GT, lat_e: 8};
        vecs[8]  = '{a: 8'h80, b: 8'h80, sgn: 1'b1, res: R_EQ, lat_e: 9};
        vecs[9]  = '{a: 8'hFF, b: 8'h00, sgn: 1'b1, res: R_LT, lat_e: 2};
        vecs[10] = '{a: 8'h3C, b: 8'h34, sgn: 1'b0, res: R_GT, lat_e: 6};

        rst_n = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs_e", {busy_e, done_e, eq_e, gt_e, lt_e}, 5'b0);
        check("reset_outputs_f", {busy_f, done_f, eq_f, gt_f, lt_f}, 5'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sgn);
            observe(vecs[i], 11, 1'b0);
        end

        // Restarts during COMPARE/DONE and operand changes after capture are ignored.
        v = '{a: 8'h10, b: 8'h20, sgn: 1'b0, res: R_LT, lat_e: 4};
        launch(v.a, v.b, v.sgn);
        observe(v, 11, 1'b1);

        // Reset in the middle of a compare.
        launch(8'h10, 8'h20, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 4) begin
                check("midreset_e", {busy_e, done_e, eq_e, gt_e, lt_e}, 5'b0);
                check("midreset_f", {busy_f, done_f, eq_f, gt_f, lt_f}, 5'b0);
                rst_n = 1'b1;
            end
            start = 1'b0;
            if (n == 3) rst_n = 1'b0;
        end
        v = '{a: 8'h03, b: 8'h03, sgn: 1'b0, res: R_EQ, lat_e: 9};
        launch(v.a, v.b, v.sgn);
        observe(v, 11, 1'b0);

        // Back-to-back: second start in the cycle right after done.
        v = '{a: 8'h5A, b: 8'h5A, sgn: 1'b0, res: R_EQ, lat_e: 9};
        launch(v.a, v.b, v.sgn);
        observe(v, 9, 1'b0);
        v = '{a: 8'hFE, b: 8'hFF, sgn: 1'b1, res: R_LT, lat_e: 9};
        launch(v.a, v.b, v.sgn);
        observe(v, 11, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
